// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: request/response controller in front of an external CAM.
// Handles LOOKUP, INSERT and FLUSH requests. It drives one-cycle search and
// write strobes to the CAM and tracks how many entries are valid. Entries at
// or above the fill count are treated as stale, so a FLUSH only has to clear
// the counter.
module cam_lookup_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_key_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_hit_o,
  output logic [IDX_W-1:0]  resp_index_o,
  output logic              resp_full_o,
  output logic [IDX_W:0]    fill_count_o,
  output logic              cam_write_enable_o,
  output logic [IDX_W-1:0]  cam_write_index_o,
  output logic [DATA_W-1:0] cam_write_data_o,
  output logic              cam_search_enable_o,
  output logic [DATA_W-1:0] cam_search_data_o,
  input  logic              cam_search_valid_i,
  input  logic [IDX_W-1:0]  cam_search_index_i
);

  localparam logic [1:0]     OP_INSERT = 2'b01;
  localparam logic [1:0]     OP_FLUSH  = 2'b10;
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_EVAL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                insert_q, insert_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [IDX_W:0]      fill_q, fill_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [IDX_W-1:0]    resp_index_q, resp_index_d;
  logic                resp_full_q, resp_full_d;
  logic                wr_en_q, wr_en_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                srch_en_q, srch_en_d;
  logic [DATA_W-1:0]   srch_data_q, srch_data_d;
  logic                hit_s;

  // A CAM match only counts when it lands inside the valid (filled) region.
  always_comb begin
    hit_s = cam_search_valid_i && ({1'b0, cam_search_index_i} < fill_q);
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_d      = state_q;
    insert_d     = insert_q;
    key_d        = key_q;
    fill_d       = fill_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_index_d = resp_index_q;
    resp_full_d  = resp_full_q;
    wr_en_d      = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    srch_en_d    = 1'b0;
    srch_data_d  = srch_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          key_d = req_key_i;
          if (req_op_i == OP_FLUSH) begin
            insert_d     = 1'b0;
            fill_d       = '0;
            resp_valid_d = 1'b1;
            resp_hit_d   = 1'b0;
            resp_index_d = '0;
            resp_full_d  = 1'b0;
            state_d      = ST_RESP;
          end else begin
            // Reserved op 11 falls through as a LOOKUP.
            insert_d    = (req_op_i == OP_INSERT);
            srch_en_d   = 1'b1;
            srch_data_d = req_key_i;
            state_d     = ST_SEARCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (hit_s) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_index_d = cam_search_index_i;
          resp_full_d  = 1'b0;
          state_d      = ST_RESP;
        end else if (!insert_q) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_index_d = '0;
          resp_full_d  = 1'b0;
          state_d      = ST_RESP;
        end else if (fill_q < DEPTH_CNT) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = fill_q[IDX_W-1:0];
          wr_data_d = key_q;
          state_d   = ST_WRITE;
        end else begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_index_d = '0;
          resp_full_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_WRITE: begin
        if (fill_q < DEPTH_CNT) begin
          fill_d = fill_q + {{IDX_W{1'b0}}, 1'b1};
        end else begin
          fill_d = fill_q;
        end
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b0;
        resp_index_d = wr_idx_q;
        resp_full_d  = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Ready is registered so it is already low in the cycle after acceptance.
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      insert_q     <= 1'b0;
      key_q        <= '0;
      fill_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_index_q <= '0;
      resp_full_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      srch_en_q    <= 1'b0;
      srch_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      insert_q     <= insert_d;
      key_q        <= key_d;
      fill_q       <= fill_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_index_q <= resp_index_d;
      resp_full_q  <= resp_full_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      srch_en_q    <= srch_en_d;
      srch_data_q  <= srch_data_d;
    end
  end

  assign req_ready_o         = ready_q;
  assign resp_valid_o        = resp_valid_q;
  assign resp_hit_o          = resp_hit_q;
  assign resp_index_o        = resp_index_q;
  assign resp_full_o         = resp_full_q;
  assign fill_count_o        = fill_q;
  assign cam_write_enable_o  = wr_en_q;
  assign cam_write_index_o   = wr_idx_q;
  assign cam_write_data_o    = wr_data_q;
  assign cam_search_enable_o = srch_en_q;
  assign cam_search_data_o   = srch_data_q;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Directed testbench for cam_lookup_ctrl with a small behavioural CAM model.
module tb_cam_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_key = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_hit;
  logic [4:0]  resp_index;
  logic        resp_full;
  logic [5:0]  fill_count;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        srch_en;
  logic [31:0] srch_data;
  logic        cam_sv = 1'b0;
  logic [4:0]  cam_si = 5'd0;

  int errors = 0;
  int checks = 0;
  int write_cnt = 0;
  int search_cnt = 0;
  int overlap_cnt = 0;

  logic [31:0] model_key [32];
  logic        model_vld [32];

  cam_lookup_ctrl #(.DATA_W(32), .DEPTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_key_i(req_key),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_hit_o(resp_hit), .resp_index_o(resp_index), .resp_full_o(resp_full),
    .fill_count_o(fill_count),
    .cam_write_enable_o(wr_en), .cam_write_index_o(wr_idx), .cam_write_data_o(wr_data),
    .cam_search_enable_o(srch_en), .cam_search_data_o(srch_data),
    .cam_search_valid_i(cam_sv), .cam_search_index_i(cam_si)
  );

  always #5 clk = ~clk;

  // Lowest-index match in the model; bit 5 = found.
  function automatic logic [5:0] cam_find(input logic [31:0] key);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 31; i >= 0; i--) begin
      if (model_vld[i] && model_key[i] == key) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

  // CAM model: writes on the write strobe, answers a search one cycle later.
  always @(posedge clk) begin
    if (wr_en) begin
      model_key[wr_idx] <= wr_data;
      model_vld[wr_idx] <= 1'b1;
    end
    if (srch_en) begin
      cam_sv <= cam_find(srch_data) >> 5;
      cam_si <= cam_find(srch_data)[4:0];
    end
    if (wr_en) write_cnt <= write_cnt + 1;
    if (srch_en) search_cnt <= search_cnt + 1;
    if (wr_en && srch_en) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request with resp_ready high and check the full response.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] key,
                        input int exp_lat, input logic eh, input logic [4:0] ei,
                        input logic ef, input logic [5:0] efill, input int ew, input int es);
    int n;
    int w0;
    int s0;
    w0 = write_cnt;
    s0 = search_cnt;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_key = key;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 12) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " hit"}, 64'(resp_hit), 64'(eh));
    chk({tag, " index"}, 64'(resp_index), 64'(ei));
    chk({tag, " full"}, 64'(resp_full), 64'(ef));
    chk({tag, " fill"}, 64'(fill_count), 64'(efill));
    chk({tag, " ready_in_resp"}, 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk({tag, " consumed"}, 64'(resp_valid), 64'd0);
    chk({tag, " writes"}, 64'(write_cnt - w0), 64'(ew));
    chk({tag, " searches"}, 64'(search_cnt - s0), 64'(es));
  endtask

  initial begin : main
    int n;
    int w0;
    for (int i = 0; i < 32; i++) begin
      model_key[i] = 32'h0;
      model_vld[i] = 1'b0;
    end

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", 64'(req_ready), 64'd0);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst fill", 64'(fill_count), 64'd0);
    chk("rst strobes", 64'({wr_en, srch_en}), 64'd0);
    chk("rst resp_index", 64'(resp_index), 64'd0);
    chk("rst search_data", 64'(srch_data), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post-rst ready", 64'(req_ready), 64'd1);

    // First insert misses and writes entry 0
    do_req("ins_a5", 2'b01, 32'hA5, 4, 1'b0, 5'd0, 1'b0, 6'd1, 1, 1);
    chk("wr_data held", 64'(wr_data), 64'hA5);
    chk("wr_idx held", 64'(wr_idx), 64'd0);
    // Re-insert hits
    do_req("ins_a5_again", 2'b01, 32'hA5, 3, 1'b1, 5'd0, 1'b0, 6'd1, 0, 1);
    // Lookup miss
    do_req("lkp_miss", 2'b00, 32'h55, 3, 1'b0, 5'd0, 1'b0, 6'd1, 0, 1);
    // Fill the rest
    for (int i = 1; i < 32; i++) begin
      do_req("fill", 2'b01, 32'h100 + 32'(i), 4, 1'b0, 5'(i), 1'b0, 6'(i + 1), 1, 1);
    end
    do_req("lkp_hit10", 2'b00, 32'h10A, 3, 1'b1, 5'd10, 1'b0, 6'd32, 0, 1);
    do_req("op11_lookup", 2'b11, 32'h105, 3, 1'b1, 5'd5, 1'b0, 6'd32, 0, 1);
    do_req("ins_full", 2'b01, 32'hDEAD, 3, 1'b0, 5'd0, 1'b1, 6'd32, 0, 1);
    // Flush, then stale entry must not hit
    do_req("flush", 2'b10, 32'h0, 1, 1'b0, 5'd0, 1'b0, 6'd0, 0, 0);
    do_req("lkp_stale", 2'b00, 32'hA5, 3, 1'b0, 5'd0, 1'b0, 6'd0, 0, 1);
    do_req("ins_after_flush", 2'b01, 32'h77, 4, 1'b0, 5'd0, 1'b0, 6'd1, 1, 1);
    chk("wr_data 77", 64'(wr_data), 64'h77);

    // Response back-pressure
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_key = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 12) begin
      @(posedge clk); #1; n++;
    end
    chk("bp latency", 64'(n), 64'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp valid", 64'(resp_valid), 64'd1);
      chk("bp hit/idx/full", 64'({resp_hit, resp_index, resp_full}), 64'({1'b1, 5'd0, 1'b0}));
      chk("bp ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp consumed", 64'(resp_valid), 64'd0);
    chk("bp ready after", 64'(req_ready), 64'd1);

    // Reset in EVAL of an INSERT miss
    w0 = write_cnt;
    req_valid = 1'b1; req_op = 2'b01; req_key = 32'h99;
    @(posedge clk); #1;          // SEARCH cycle
    req_valid = 1'b0;
    @(posedge clk); #1;          // EVAL cycle
    rst = 1'b0;
    @(posedge clk); #1;
    chk("evalrst wr_en", 64'(wr_en), 64'd0);
    chk("evalrst fill", 64'(fill_count), 64'd0);
    chk("evalrst resp", 64'({resp_valid, resp_hit, resp_index, resp_full}), 64'd0);
    chk("evalrst regs", 64'({wr_idx, wr_data, srch_data}), 64'd0);
    chk("evalrst ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("evalrst no write", 64'(write_cnt - w0), 64'd0);
    chk("evalrst idle", 64'(req_ready), 64'd1);

    // Reset while the write strobe is up
    req_valid = 1'b1; req_op = 2'b01; req_key = 32'h42;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;          // WRITE cycle
    chk("wrrst strobe up", 64'(wr_en), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("wrrst strobe off", 64'(wr_en), 64'd0);
    chk("wrrst fill", 64'(fill_count), 64'd0);
    chk("wrrst resp_valid", 64'(resp_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("wrrst ready", 64'(req_ready), 64'd1);

    chk("strobe overlap", 64'(overlap_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
